// File: rtl/adder_share_arb.sv
// Round-robin front end that time-shares one external prefix adder between an
// ALU requester (port 0) and an address-generation requester (port 1).
module adder_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic             ptr_reg;
  logic             owner_reg;
  logic             sub_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       grant;
  logic             in_calc;

  // Grant is only offered in IDLE and never while reset is held.
  always_comb begin
    grant = 2'b00;
    if (rst_n && state_reg == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign busy      = (state_reg != IDLE);
  assign in_calc   = (state_reg == CALC);

  // Operands are forced to zero outside CALC so the shared tree stays quiet.
  assign add_a   = in_calc ? a_reg : '0;
  assign add_b   = in_calc ? (sub_reg ? ~b_reg : b_reg) : '0;
  assign add_cin = in_calc & sub_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp_valid
    assign resp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      owner_reg <= 1'b0;
      sub_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
      resp_ovf  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            owner_reg <= grant[1];
            a_reg     <= grant[1] ? req1_a   : req0_a;
            b_reg     <= grant[1] ? req1_b   : req0_b;
            sub_reg   <= grant[1] ? req1_sub : req0_sub;
            state_reg <= CALC;
          end
        end
        CALC: begin
          resp_sum  <= add_sum;
          resp_cout <= add_cout;
          resp_ovf  <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                       (add_sum[WIDTH-1] != add_a[WIDTH-1]);
          state_reg <= RESP;
        end
        RESP: begin
          // Pointer moves only on completion so contention alternates strictly.
          if (resp_ready[owner_reg]) begin
            ptr_reg   <= ~owner_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
